// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetch_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int INST_W_DEF = 16;

  localparam logic [15:0] NOP = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: decode-side control/delivery plus the instruction memory port.
interface inst_fetch_if
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF
);

  // Handshakes: a memory read transfers on the cycle O_MEM_REQ=1 and I_MEM_ACK=1
  // (REQ/ADDR held stable until then); an instruction transfers to the decoder
  // on the cycle O_VLD=1 and I_STALL=0 (O_INST/O_PC held stable until then).
  logic              I_EN;
  logic              I_STALL;
  logic              I_BR_TAKEN;
  logic [ADDR_W-1:0] I_BR_ADDR;
  logic              O_MEM_REQ;
  logic [ADDR_W-1:0] O_MEM_ADDR;
  logic              I_MEM_ACK;
  logic [INST_W-1:0] I_MEM_DATA;
  logic [INST_W-1:0] O_INST;
  logic [ADDR_W-1:0] O_PC;
  logic              O_VLD;

  modport master (
    input  I_EN, I_STALL, I_BR_TAKEN, I_BR_ADDR, I_MEM_ACK, I_MEM_DATA,
    output O_MEM_REQ, O_MEM_ADDR, O_INST, O_PC, O_VLD
  );

  modport slave (
    output I_EN, I_STALL, I_BR_TAKEN, I_BR_ADDR, I_MEM_ACK, I_MEM_DATA,
    input  O_MEM_REQ, O_MEM_ADDR, O_INST, O_PC, O_VLD
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// Two-entry skid: output register presented to decode plus one hold entry.
module fetch_skid_buf
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [INST_W-1:0] push_inst,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_vld,
  output logic              hold_vld
);

  logic [INST_W-1:0] hold_inst;
  logic [ADDR_W-1:0] hold_pc;
  logic              out_free;

  // Output register can take a new entry when empty or being consumed.
  assign out_free = !out_vld || pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_inst  <= INST_W'(NOP);
      out_pc    <= '0;
      out_vld   <= 1'b0;
      hold_inst <= INST_W'(NOP);
      hold_pc   <= '0;
      hold_vld  <= 1'b0;
    end else if (flush) begin
      out_vld  <= 1'b0;
      hold_vld <= 1'b0;
    end else if (out_free) begin
      if (hold_vld) begin
        out_inst <= hold_inst;
        out_pc   <= hold_pc;
        out_vld  <= 1'b1;
        hold_vld <= push;
        if (push) begin
          hold_inst <= push_inst;
          hold_pc   <= push_pc;
        end
      end else if (push) begin
        out_inst <= push_inst;
        out_pc   <= push_pc;
        out_vld  <= 1'b1;
      end else begin
        out_vld <= 1'b0;
      end
    end else if (push) begin
      hold_inst <= push_inst;
      hold_pc   <= push_pc;
      hold_vld  <= 1'b1;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, single-outstanding memory reads, 2-entry skid, branch flush.
// Optional INST_FETCH_PERF_EN adds consumed-instruction and redirect counters.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INST_W   = INST_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         I_CLK,
  input  logic         I_RSTN,
  inst_fetch_if.master bus,
`ifdef INST_FETCH_PERF_EN
  output logic [15:0]  O_FETCH_CNT,
  output logic [15:0]  O_FLUSH_CNT,
`endif
  output fetch_state_t dbg_state
);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              mem_req, req_n;
  logic [ADDR_W-1:0] mem_addr, addr_n;
  logic              push;
  logic              pop;
  logic              ack_fire;
  logic              out_vld;
  logic              hold_vld;

  assign ack_fire = mem_req && bus.I_MEM_ACK;
  assign pop      = out_vld && !bus.I_STALL;

  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      mem_req  <= req_n;
      mem_addr <= addr_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = mem_req;
    addr_n  = mem_addr;
    push    = 1'b0;
    if (bus.I_BR_TAKEN) begin
      // Redirect wins over everything; an un-acked request must still complete.
      pc_n = bus.I_BR_ADDR;
      if (mem_req && !bus.I_MEM_ACK) begin
        state_n = S_DRAIN;
      end else if (bus.I_EN) begin
        state_n = S_REQ;
        req_n   = 1'b1;
        addr_n  = bus.I_BR_ADDR;
      end else begin
        state_n = S_IDLE;
        req_n   = 1'b0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.I_EN && !hold_vld) begin
            state_n = S_REQ;
            req_n   = 1'b1;
            addr_n  = pc;
          end
        end
        S_REQ: begin
          if (ack_fire) begin
            push = 1'b1;
            pc_n = pc + ADDR_W'(1);
            // Word lands in the hold entry when the output is occupied and stalled.
            if (out_vld && !pop) begin
              state_n = S_HOLD;
              req_n   = 1'b0;
            end else if (bus.I_EN) begin
              addr_n = pc + ADDR_W'(1);
            end else begin
              state_n = S_IDLE;
              req_n   = 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (pop) begin
            if (bus.I_EN) begin
              state_n = S_REQ;
              req_n   = 1'b1;
              addr_n  = pc;
            end else begin
              state_n = S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if (ack_fire) begin
            if (bus.I_EN) begin
              state_n = S_REQ;
              req_n   = 1'b1;
              addr_n  = pc;
            end else begin
              state_n = S_IDLE;
              req_n   = 1'b0;
            end
          end
        end
        default: begin
          state_n = S_IDLE;
          req_n   = 1'b0;
        end
      endcase
    end
  end

  fetch_skid_buf #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_skid (
    .clk       (I_CLK),
    .rst_n     (I_RSTN),
    .flush     (bus.I_BR_TAKEN),
    .push      (push),
    .push_inst (bus.I_MEM_DATA),
    .push_pc   (pc),
    .pop       (pop),
    .out_inst  (bus.O_INST),
    .out_pc    (bus.O_PC),
    .out_vld   (out_vld),
    .hold_vld  (hold_vld)
  );

  assign bus.O_MEM_REQ  = mem_req;
  assign bus.O_MEM_ADDR = mem_addr;
  assign bus.O_VLD      = out_vld;
  assign dbg_state      = state;

`ifdef INST_FETCH_PERF_EN
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      O_FETCH_CNT <= '0;
      O_FLUSH_CNT <= '0;
    end else begin
      if (pop)            O_FETCH_CNT <= O_FETCH_CNT + 16'd1;
      if (bus.I_BR_TAKEN) O_FLUSH_CNT <= O_FLUSH_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: free run, stall, drain redirect, same-cycle redirect,
// PC wrap (second instance at RESET_PC=FFFE) and asynchronous reset.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic ack_en;
  logic ack_en2;
  int   n_checks = 0;
  int   n_errors = 0;

  inst_fetch_if bus ();
  inst_fetch_if bus2 ();

  fetch_state_t st;
  fetch_state_t st2;

  assign bus.I_MEM_ACK   = ack_en;
  assign bus.I_MEM_DATA  = bus.O_MEM_ADDR ^ 16'hA5A5;
  assign bus2.I_MEM_ACK  = ack_en2;
  assign bus2.I_MEM_DATA = bus2.O_MEM_ADDR ^ 16'hA5A5;

`ifdef INST_FETCH_PERF_EN
  logic [15:0] fetch_cnt, flush_cnt, fetch_cnt2, flush_cnt2;
`endif

  inst_fetch dut (
    .I_CLK       (clk),
    .I_RSTN      (rst_n),
    .bus         (bus),
`ifdef INST_FETCH_PERF_EN
    .O_FETCH_CNT (fetch_cnt),
    .O_FLUSH_CNT (flush_cnt),
`endif
    .dbg_state   (st)
  );

  inst_fetch #(.RESET_PC(16'hFFFE)) dut2 (
    .I_CLK       (clk),
    .I_RSTN      (rst_n),
    .bus         (bus2),
`ifdef INST_FETCH_PERF_EN
    .O_FETCH_CNT (fetch_cnt2),
    .O_FLUSH_CNT (flush_cnt2),
`endif
    .dbg_state   (st2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [15:0] pc_exp);
    check({tag, "_vld"}, 32'(bus.O_VLD), 32'd1);
    check({tag, "_pc"}, 32'(bus.O_PC), 32'(pc_exp));
    check({tag, "_inst"}, 32'(bus.O_INST), 32'(pc_exp ^ 16'hA5A5));
  endtask

  task automatic check_reset();
    check("rst_req", 32'(bus.O_MEM_REQ), 32'd0);
    check("rst_addr", 32'(bus.O_MEM_ADDR), 32'h0000);
    check("rst_inst", 32'(bus.O_INST), 32'h0000);
    check("rst_pc", 32'(bus.O_PC), 32'h0000);
    check("rst_vld", 32'(bus.O_VLD), 32'd0);
    check("rst_state", 32'(st), 32'(S_IDLE));
    check("rst2_addr", 32'(bus2.O_MEM_ADDR), 32'hFFFE);
    check("rst2_vld", 32'(bus2.O_VLD), 32'd0);
`ifdef INST_FETCH_PERF_EN
    check("rst_fetch_cnt", 32'(fetch_cnt), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
  endtask

  initial begin
    logic [15:0] wpc;
    rst_n           = 1'b0;
    ack_en          = 1'b0;
    ack_en2         = 1'b0;
    bus.I_EN        = 1'b0;
    bus.I_STALL     = 1'b0;
    bus.I_BR_TAKEN  = 1'b0;
    bus.I_BR_ADDR   = '0;
    bus2.I_EN       = 1'b0;
    bus2.I_STALL    = 1'b0;
    bus2.I_BR_TAKEN = 1'b0;
    bus2.I_BR_ADDR  = '0;
    repeat (2) tick();
    check_reset();

    // Free run with ACK every cycle; ACK while REQ=0 must be ignored.
    rst_n     = 1'b1;
    bus.I_EN  = 1'b1;
    ack_en    = 1'b1;
    bus2.I_EN = 1'b1;
    ack_en2   = 1'b1;
    tick();
    check("first_req", 32'(bus.O_MEM_REQ), 32'd1);
    check("first_addr", 32'(bus.O_MEM_ADDR), 32'h0000);
    check("first_vld", 32'(bus.O_VLD), 32'd0);
    check("wrap_addr0", 32'(bus2.O_MEM_ADDR), 32'hFFFE);
    tick();
    for (int k = 0; k < 5; k++) begin
      check_out($sformatf("run%0d", k), 16'(k));
      if (k < 3) begin
        wpc = 16'hFFFE + 16'(k);
        check($sformatf("wrap_pc%0d", k), 32'(bus2.O_PC), 32'(wpc));
        wpc = wpc + 16'd1;
        check($sformatf("wrap_addr%0d", k + 1), 32'(bus2.O_MEM_ADDR), 32'(wpc));
      end
      if (k < 4) tick();
    end

    // Stall while O_PC=4: word 5 goes to hold, REQ drops.
    bus.I_STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("stall%0d", i), 16'd4);
      check($sformatf("stall%0d_req", i), 32'(bus.O_MEM_REQ), 32'd0);
      if (i == 0) check("stall_state", 32'(st), 32'(S_HOLD));
    end
    bus.I_STALL = 1'b0;
    tick();
    check_out("unstall5", 16'd5);
    check("unstall_req", 32'(bus.O_MEM_REQ), 32'd1);
    check("unstall_addr", 32'(bus.O_MEM_ADDR), 32'h0006);
    tick();
    check_out("unstall6", 16'd6);
    tick();
    check_out("unstall7", 16'd7);

    // Redirect while request for 8 is pending without ACK.
    ack_en = 1'b0;
    tick();
    check("pend_req", 32'(bus.O_MEM_REQ), 32'd1);
    check("pend_addr", 32'(bus.O_MEM_ADDR), 32'h0008);
    check("pend_vld", 32'(bus.O_VLD), 32'd0);
    bus.I_BR_TAKEN = 1'b1;
    bus.I_BR_ADDR  = 16'h0100;
    tick();
    bus.I_BR_TAKEN = 1'b0;
    check("drain_state", 32'(st), 32'(S_DRAIN));
    check("drain_req", 32'(bus.O_MEM_REQ), 32'd1);
    check("drain_addr", 32'(bus.O_MEM_ADDR), 32'h0008);
    tick();
    check("drain2_state", 32'(st), 32'(S_DRAIN));
    check("drain2_addr", 32'(bus.O_MEM_ADDR), 32'h0008);
    ack_en = 1'b1;
    tick();
    check("redir_state", 32'(st), 32'(S_REQ));
    check("redir_addr", 32'(bus.O_MEM_ADDR), 32'h0100);
    check("redir_vld", 32'(bus.O_VLD), 32'd0);
    tick();
    check_out("tgt100", 16'h0100);
    tick();
    check_out("tgt101", 16'h0101);

    // Redirect in the same cycle as ACK of 0x102.
    bus.I_BR_TAKEN = 1'b1;
    bus.I_BR_ADDR  = 16'h0200;
    tick();
    bus.I_BR_TAKEN = 1'b0;
    check("sameack_vld", 32'(bus.O_VLD), 32'd0);
    check("sameack_req", 32'(bus.O_MEM_REQ), 32'd1);
    check("sameack_addr", 32'(bus.O_MEM_ADDR), 32'h0200);
    tick();
    check_out("tgt200", 16'h0200);
    tick();
    check_out("tgt201", 16'h0201);
`ifdef INST_FETCH_PERF_EN
    check("fetch_cnt", 32'(fetch_cnt), 32'd11);
    check("flush_cnt", 32'(flush_cnt), 32'd2);
`endif

    // Asynchronous reset mid-stream, away from any clock edge.
    check("pre_rst_req", 32'(bus.O_MEM_REQ), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
